hex_peek_display: RTL and testbench



---
 rtl/hex_peek_display_pkg.sv | 11 +
 rtl/hex_peek_display_hex7seg.sv | 11 +
 rtl/hex_peek_display.sv | 86 ++++++++
 tb/tb_hex_peek_display.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hex_peek_display_pkg.sv
// hex_pkg: segment constants, hex digit codes and peek FSM states
package hex_pkg;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_P = 8'h8C;
  localparam logic [7:0] SEG_D = 8'hA1;
  localparam logic [7:0] HEX_CODE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
  typedef enum logic [1:0] {SHOW, REQ, HOLD} state_t;
endpackage

// File: rtl/hex_peek_display_hex7seg.sv
// hex7seg: 4-bit digit to active-low seven-segment code with dp and blanking
module hex7seg
  import hex_pkg::*;
(
  input  logic [3:0] d,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);
  assign seg = blank ? SEG_BLANK : {~dp, HEX_CODE[d][6:0]};
endmodule

// File: rtl/hex_peek_display.sv
// hex_peek_display: shows the result bus in hex, peeks register-file entries on key presses
module hex_peek_display
  import hex_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int NREG = 8,
  parameter int PEEK_HOLD = 250_000_000
) (
  input  logic                    CLK,
  input  logic                    CLRb,
  input  logic                    PK,
  input  logic [DATA_W-1:0]       Bus,
  input  logic                    Done,
  output logic                    RdReq,
  output logic [$clog2(NREG)-1:0] RdAddr,
  input  logic                    RdAck,
  input  logic [DATA_W-1:0]       RdData,
  output logic [7:0]              HEX0,
  output logic [7:0]              HEX1,
  output logic [7:0]              HEX2,
  output logic [7:0]              HEX3,
  output logic [7:0]              HEX4,
  output logic [7:0]              HEX5
);
  localparam int AW = $clog2(NREG);
  localparam int CW = PEEK_HOLD > 1 ? $clog2(PEEK_HOLD) : 1;
  state_t state;
  logic pk_q;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] data;
  logic press, timeout, use_hold, load;
  logic [DATA_W-1:0] val;
  logic [11:0] vz;
  logic [23:0] nibs;
  logic [5:0] dp, blank;
  logic [7:0] seg [6];
  // Pick what the display latches this cycle: bus view, or the peeked value (live ack data or latched copy)
  always_comb begin
    press = PK & ~pk_q;
    timeout = state == HOLD && cnt == '0 && !press;
    use_hold = state == REQ || (state == HOLD && !timeout);
    load = state != REQ || RdAck;
    val = !use_hold ? Bus : state == REQ ? RdData : data;
    vz = 12'(val);
    nibs = {4'hD, 4'(RdAddr), 4'h0, vz};
    dp = 6'b010000;
    blank = {~Done, ~use_hold, 1'b1, 3'b000};
  end
  for (genvar i = 0; i < 6; i++) begin : g_dig
    hex7seg u_dig (.d(nibs[4*i+:4]), .dp(dp[i]), .blank(blank[i]), .seg(seg[i]));
  end
  // Peek FSM with registered display, request and address
  always_ff @(posedge CLK or negedge CLRb) begin
    if (!CLRb) begin
      state <= SHOW;
      pk_q <= 1'b0;
      cnt <= '0;
      data <= '0;
      RdReq <= 1'b0;
      RdAddr <= '0;
      {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} <= {6{SEG_BLANK}};
    end else begin
      pk_q <= PK;
      if (load) {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} <= {use_hold ? SEG_P : seg[5], seg[4], seg[3], seg[2], seg[1], seg[0]};
      case (state)
        SHOW: if (press) begin
          state <= REQ;
          RdReq <= 1'b1;
        end
        REQ: if (RdAck) begin
          data <= RdData;
          RdReq <= 1'b0;
          cnt <= CW'(PEEK_HOLD - 1);
          state <= HOLD;
        end
        HOLD: if (press) begin
          RdAddr <= RdAddr == AW'(NREG - 1) ? '0 : RdAddr + 1'b1;
          RdReq <= 1'b1;
          state <= REQ;
        end else if (cnt == '0) state <= SHOW;
        else cnt <= cnt - 1'b1;
        default: state <= SHOW;
      endcase
    end
  end
endmodule

// File: tb/tb_hex_peek_display.sv
// tb_hex_peek_display: randomized and directed checks against a cycle-level reference model
module tb_hex_peek_display;
  localparam int PH = 20;
  localparam int NR = 8;
  logic clk = 0, clrb = 0, pk = 0, done = 0, ack = 0;
  logic [9:0] bus = 0, rdd = 0;
  logic req;
  logic [2:0] addr;
  logic [7:0] h0, h1, h2, h3, h4, h5;
  int n_cmp = 0, n_err = 0;
  logic [7:0] code [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  always #5 clk = ~clk;

  hex_peek_display #(.DATA_W(10), .NREG(NR), .PEEK_HOLD(PH)) dut (
    .CLK(clk), .CLRb(clrb), .PK(pk), .Bus(bus), .Done(done),
    .RdReq(req), .RdAddr(addr), .RdAck(ack), .RdData(rdd),
    .HEX0(h0), .HEX1(h1), .HEX2(h2), .HEX3(h3), .HEX4(h4), .HEX5(h5)
  );

  function automatic logic [47:0] disp(input logic hold, input logic [9:0] v, input logic [2:0] a, input logic d);
    logic [11:0] z;
    logic [47:0] r;
    z = {2'b00, v};
    r[7:0] = code[z[3:0]];
    r[15:8] = code[z[7:4]];
    r[23:16] = code[z[11:8]];
    r[31:24] = 8'hFF;
    r[39:32] = hold ? (code[{1'b0, a}] & 8'h7F) : 8'hFF;
    r[47:40] = hold ? 8'h8C : (d ? 8'hA1 : 8'hFF);
    return r;
  endfunction

  // reference model: mode 0 = bus view, 1 = waiting for ack, 2 = showing peeked value
  int m_mode;
  logic [2:0] m_addr;
  logic m_req, m_pk;
  logic [47:0] m_disp;
  int cyc = 0, ack_cyc = 0;
  always @(posedge clk or negedge clrb) begin
    if (!clrb) begin
      m_mode = 0; m_addr = 0; m_req = 0; m_pk = 0; m_disp = '1;
    end else begin
      if (m_mode == 0) begin
        m_disp = disp(0, bus, m_addr, done);
        if (pk && !m_pk) begin m_mode = 1; m_req = 1; end
      end else if (m_mode == 1) begin
        if (ack) begin
          m_req = 0; ack_cyc = cyc; m_mode = 2;
          m_disp = disp(1, rdd, m_addr, done);
        end
      end else begin
        if (pk && !m_pk) begin
          m_addr = 3'((int'(m_addr) + 1) % NR); m_mode = 1; m_req = 1;
        end else if (cyc - ack_cyc == PH) begin
          m_mode = 0; m_disp = disp(0, bus, m_addr, done);
        end
      end
      m_pk = pk;
      cyc++;
    end
  end

  logic [51:0] obs, expv;
  assign obs = {h5, h4, h3, h2, h1, h0, req, addr};
  assign expv = {m_disp, m_req, m_addr};

  task automatic test_reset();
    repeat (3) begin @(negedge clk); bus = 10'($urandom); end
    #2 clrb = 0;
    #1 n_cmp++;
    if ({obs[51:4], obs[3]} !== {48'hFFFF_FFFF_FFFF, 1'b0}) begin
      n_err++; $display("FAIL reset_async got=%h want=ffffffffffff0", obs[51:3]);
    end
    @(negedge clk); clrb = 1; bus = 10'h3FF; done = 0;
    @(negedge clk); n_cmp++;
    if ({h2, h1, h0, h5} !== 32'hB08E8EFF) begin
      n_err++; $display("FAIL show_3ff got=%h want=b08e8eff", {h2, h1, h0, h5});
    end
    done = 1;
    @(negedge clk); n_cmp++;
    if (h5 !== 8'hA1) begin n_err++; $display("FAIL done_d got=%h want=a1", h5); end
    n_cmp++;
    if (obs !== expv) begin n_err++; $display("FAIL reset_model got=%h want=%h", obs, expv); end
  endtask

  task automatic test_handshake();
    logic [47:0] snap;
    pk = 1;
    @(negedge clk); pk = 0; n_cmp++;
    if ({req, addr} !== 4'b1000) begin n_err++; $display("FAIL req_start got=%b want=1000", {req, addr}); end
    snap = obs[51:4];
    repeat (3) begin
      @(negedge clk); n_cmp++;
      if ({obs[51:4], req} !== {snap, 1'b1}) begin
        n_err++; $display("FAIL req_wait got=%h want=%h", {obs[51:4], req}, {snap, 1'b1});
      end
    end
    ack = 1; rdd = 10'h2A5;
    @(negedge clk); ack = 0; n_cmp++;
    if ({h2, h1, h0, h4, h5, req} !== {40'hA48892408C, 1'b0}) begin
      n_err++; $display("FAIL peek_show got=%h want=%h", {h2, h1, h0, h4, h5, req}, {40'hA48892408C, 1'b0});
    end
  endtask

  task automatic test_timeout();
    bus = 10'h1C3; done = 1;
    for (int k = 1; k < PH; k++) begin
      @(negedge clk); n_cmp++;
      if (h5 !== 8'h8C) begin n_err++; $display("FAIL hold_early k=%0d got=%h want=8c", k, h5); end
    end
    @(negedge clk); n_cmp++;
    if (obs[51:4] !== disp(0, 10'h1C3, 0, 1)) begin
      n_err++; $display("FAIL timeout_show got=%h want=%h", obs[51:4], disp(0, 10'h1C3, 0, 1));
    end
    pk = 1;
    @(negedge clk); pk = 0; n_cmp++;
    if ({req, addr} !== 4'b1000) begin n_err++; $display("FAIL repeek_addr got=%b want=1000", {req, addr}); end
  endtask

  task automatic test_step_wrap();
    logic [9:0] v;
    logic [2:0] ea;
    ea = 0;
    for (int n = 0; n <= 8; n++) begin
      if (n > 0) begin
        pk = 1;
        @(negedge clk); pk = 0; ea = 3'((int'(ea) + 1) % NR); n_cmp++;
        if ({req, addr} !== {1'b1, ea}) begin
          n_err++; $display("FAIL step_addr n=%0d got=%b want=%b", n, {req, addr}, {1'b1, ea});
        end
      end
      v = 10'($urandom); ack = 1; rdd = v;
      @(negedge clk); ack = 0; n_cmp++;
      if ({obs[51:4], req} !== {disp(1, v, ea, done), 1'b0}) begin
        n_err++; $display("FAIL step_disp n=%0d got=%h want=%h", n, obs[51:4], disp(1, v, ea, done));
      end
      if (ea == 3'd7) begin
        n_cmp++;
        if (h4 !== 8'h78) begin n_err++; $display("FAIL idx7_dp got=%h want=78", h4); end
      end
    end
  endtask

  task automatic test_edges();
    int rises;
    logic prev;
    for (int i = 0; i < 40 && h5 === 8'h8C; i++) @(negedge clk);
    n_cmp++;
    if (h5 === 8'h8C) begin n_err++; $display("FAIL hold_wait got=%h want=not 8c", h5); end
    rises = 0; prev = req; pk = 1;
    repeat (100) begin
      @(negedge clk);
      if (req && !prev) rises++;
      prev = req; ack = req; rdd = 10'($urandom);
    end
    pk = 0; ack = 0; n_cmp++;
    if (rises !== 1) begin n_err++; $display("FAIL held_pk got=%0d want=1 requests", rises); end
    @(negedge clk); pk = 1;
    @(negedge clk); pk = 0; n_cmp++;
    if ({req, addr} !== 4'b1000) begin n_err++; $display("FAIL edge_req got=%b want=1000", {req, addr}); end
    @(negedge clk); pk = 1;
    @(negedge clk); pk = 0;
    @(negedge clk); ack = 1; rdd = 10'h155;
    @(negedge clk); ack = 0; n_cmp++;
    if ({h5, req, addr} !== {8'h8C, 4'b0000}) begin
      n_err++; $display("FAIL req_press_ack got=%h want=8c0", {h5, req, addr});
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); n_cmp++;
      if ({req, addr} !== 4'b0000) begin n_err++; $display("FAIL req_press_ignored got=%b want=0000", {req, addr}); end
    end
    repeat (PH - 4) @(negedge clk);
    n_cmp++;
    if ({h5, req} !== {8'h8C, 1'b0}) begin n_err++; $display("FAIL last_hold got=%h want=8c0", {h5, req}); end
    pk = 1;
    @(negedge clk); pk = 0; n_cmp++;
    if ({h5, req, addr} !== {8'h8C, 4'b1001}) begin
      n_err++; $display("FAIL press_on_timeout got=%h want=8c9", {h5, req, addr});
    end
    n_cmp++;
    if (obs !== expv) begin n_err++; $display("FAIL edges_model got=%h want=%h", obs, expv); end
  endtask

  task automatic test_reset_req();
    n_cmp++;
    if (req !== 1'b1) begin n_err++; $display("FAIL pre_reset_req got=%b want=1", req); end
    #2 clrb = 0;
    #1 n_cmp++;
    if (obs !== {48'hFFFF_FFFF_FFFF, 4'b0000}) begin
      n_err++; $display("FAIL reset_in_req got=%h want=ffffffffffff0", obs);
    end
    @(negedge clk); clrb = 1; #1 n_cmp++;
    if (obs[51:4] !== 48'hFFFF_FFFF_FFFF) begin n_err++; $display("FAIL blank_till_clock got=%h", obs[51:4]); end
    @(negedge clk); n_cmp++;
    if (obs !== {disp(0, bus, 0, done), 4'b0000}) begin
      n_err++; $display("FAIL after_reset_show got=%h want=%h", obs, {disp(0, bus, 0, done), 4'b0000});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); n_cmp++;
      if (obs !== expv) begin n_err++; $display("FAIL random cyc=%0d got=%h want=%h", i, obs, expv); end
      bus = 10'($urandom);
      if ($urandom_range(9) == 0) done = ~done;
      if ($urandom_range(7) == 0) pk = ~pk;
      ack = req && $urandom_range(3) == 0;
      rdd = 10'($urandom);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    clrb = 1;
    test_reset();
    test_handshake();
    test_timeout();
    test_step_wrap();
    test_edges();
    test_reset_req();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
